// File: rtl/app_mul_accum_pkg.sv
// Shared types and constants for the multiply-accumulate result path.
//   app_acc_state_t   : accumulator job state (idle / accumulating / result held)
//   APP_ACC_W_DEFAULT : default accumulator width
//   APP_SCALAR_W      : width of one product word (scalar_t)
package app_mul_accum_pkg;

    typedef enum logic [1:0] {ACC_IDLE, ACC_ACCUM, ACC_DONE} app_acc_state_t;

    localparam int APP_ACC_W_DEFAULT = 48;
    localparam int APP_SCALAR_W      = 32;

endpackage

// File: rtl/app_mul_accum_acc_adder.sv
// Combinational accumulate step: extends a 32-bit product to ACC_W bits,
// adds it to the running sum, flags overflow and optionally clamps.
// Ports:
//   acc      in  ACC_W  current accumulator value
//   product  in  32     product word
//   sign     in  1      1 = two's-complement job, 0 = unsigned
//   next_acc out ACC_W  accumulator after this add
//   ovf      out 1      this add overflowed
module app_acc_adder
    import app_mul_accum_pkg::*;
#(
    parameter int ACC_W    = APP_ACC_W_DEFAULT,
    parameter int SATURATE = 0
) (
    input  logic [ACC_W-1:0]        acc,
    input  logic [APP_SCALAR_W-1:0] product,
    input  logic                    sign,
    output logic [ACC_W-1:0]        next_acc,
    output logic                    ovf
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum;

    always_comb begin
        ext = sign ? {{(ACC_W-APP_SCALAR_W){product[APP_SCALAR_W-1]}}, product}
                   : {{(ACC_W-APP_SCALAR_W){1'b0}}, product};
        sum = {1'b0, acc} + {1'b0, ext};

        // Unsigned: carry out. Signed: like-signed addends giving an opposite-signed sum.
        if (sign)
            ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        else
            ovf = sum[ACC_W];

        next_acc = sum[ACC_W-1:0];
        if ((SATURATE != 0) && ovf) begin
            if (!sign)
                next_acc = '1;
            else if (acc[ACC_W-1])
                next_acc = {1'b1, {(ACC_W-1){1'b0}}};
            else
                next_acc = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/app_mul_accum.sv
// Accumulates a programmed number of approximate-multiplier products into a
// wide sum and hands the result back over a valid/ready handshake.
// Ports:
//   clk, reset (sync, active-low)
//   start_en/start_count/start_sign : job start, accepted only while idle
//   busy                            : any state other than idle
//   prod_valid/prod_ready/prod_data : product stream in
//   result_valid/result_ready       : result handshake
//   result_data/result_overflow     : sum and sticky overflow, stable while valid
//
// state     | meaning
// ACC_IDLE  | waiting for start_en
// ACC_ACCUM | accepting products until the count is exhausted
// ACC_DONE  | result held until the consumer takes it
module app_mul_accum
    import app_mul_accum_pkg::*;
#(
    parameter int ACC_W    = APP_ACC_W_DEFAULT,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_en,
    input  logic [CNT_W-1:0]        start_count,
    input  logic                    start_sign,
    output logic                    busy,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    input  logic [APP_SCALAR_W-1:0] prod_data,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [ACC_W-1:0]        result_data,
    output logic                    result_overflow
);

    app_acc_state_t   state;
    logic [CNT_W-1:0] remaining;
    logic             sign_q;
    logic [ACC_W-1:0] acc;
    logic             ovf_sticky;
    logic [ACC_W-1:0] next_acc;
    logic             add_ovf;

    app_acc_adder #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .acc      (acc),
        .product  (prod_data),
        .sign     (sign_q),
        .next_acc (next_acc),
        .ovf      (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ACC_IDLE;
            remaining       <= '0;
            sign_q          <= 1'b0;
            acc             <= '0;
            ovf_sticky      <= 1'b0;
            busy            <= 1'b0;
            prod_ready      <= 1'b0;
            result_valid    <= 1'b0;
            result_data     <= '0;
            result_overflow <= 1'b0;
        end else begin
            case (state)
                ACC_IDLE: begin
                    if (start_en) begin
                        remaining  <= start_count;
                        sign_q     <= start_sign;
                        acc        <= '0;
                        ovf_sticky <= 1'b0;
                        busy       <= 1'b1;
                        if (start_count == '0) begin
                            state           <= ACC_DONE;
                            result_valid    <= 1'b1;
                            result_data     <= '0;
                            result_overflow <= 1'b0;
                        end else begin
                            state      <= ACC_ACCUM;
                            prod_ready <= 1'b1;
                        end
                    end
                end
                ACC_ACCUM: begin
                    if (prod_valid && prod_ready) begin
                        acc        <= next_acc;
                        ovf_sticky <= ovf_sticky | add_ovf;
                        remaining  <= remaining - CNT_W'(1);
                        // Last product: publish the sum directly so valid rises next cycle.
                        if (remaining == CNT_W'(1)) begin
                            state           <= ACC_DONE;
                            prod_ready      <= 1'b0;
                            result_valid    <= 1'b1;
                            result_data     <= next_acc;
                            result_overflow <= ovf_sticky | add_ovf;
                        end
                    end
                end
                ACC_DONE: begin
                    if (result_ready) begin
                        state        <= ACC_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= ACC_IDLE;
                    busy         <= 1'b0;
                    prod_ready   <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
